// File: rtl/fifo_pkg.sv
// Shared types and pointer arithmetic for the parametrised single-clock FIFO.
package fifo_pkg;

    typedef enum logic {
        FIFO_STD  = 1'b0,
        FIFO_FWFT = 1'b1
    } fifo_mode_e;

    // Wrap is explicit so DEPTH does not have to be a power of two.
    function automatic logic [31:0] next_ptr(input logic [31:0] ptr, input logic [31:0] depth);
        return (ptr == depth - 32'd1) ? 32'd0 : ptr + 32'd1;
    endfunction

endpackage

// File: rtl/sync_fifo_param_if.sv
// Producer/consumer handshake bundle for sync_fifo_param; master drives requests, slave is the FIFO.
interface sync_fifo_param_if #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 32
);
    logic                           i_flush;
    logic                           i_wr;
    logic [WIDTH-1:0]               i_din;
    logic                           i_rd;
    logic [WIDTH-1:0]               o_dout;
    logic                           o_dout_valid;
    logic                           o_full;
    logic                           o_empty;
    logic                           o_almost_full;
    logic                           o_almost_empty;
    logic [$clog2(DEPTH+1)-1:0]     o_count;
    logic                           o_overflow;
    logic                           o_underflow;

    modport master (
        output i_flush, i_wr, i_din, i_rd,
        input  o_dout, o_dout_valid, o_full, o_empty, o_almost_full,
               o_almost_empty, o_count, o_overflow, o_underflow
    );

    modport slave (
        input  i_flush, i_wr, i_din, i_rd,
        output o_dout, o_dout_valid, o_full, o_empty, o_almost_full,
               o_almost_empty, o_count, o_overflow, o_underflow
    );
endinterface

// File: rtl/fifo_sdp_ram.sv
// Simple dual-port storage: synchronous write, asynchronous read. Contents are never cleared.
module fifo_sdp_ram #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 32
) (
    input  logic                       i_clk,
    input  logic                       i_we,
    input  logic [$clog2(DEPTH)-1:0]   i_waddr,
    input  logic [WIDTH-1:0]           i_wdata,
    input  logic [$clog2(DEPTH)-1:0]   i_raddr,
    output logic [WIDTH-1:0]           o_rdata
);
    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/sync_fifo_param.sv
// Single-clock FIFO with STD or first-word fall-through read, occupancy count,
// programmable almost flags, flush and sticky overflow/underflow.
module sync_fifo_param
    import fifo_pkg::*;
#(
    parameter int WIDTH    = 16,
    parameter int DEPTH    = 32,
    parameter int FWFT     = 0,
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = 2
) (
    input  logic              i_clk,
    input  logic              i_rst,
    sync_fifo_param_if.slave  bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam fifo_mode_e MODE = (FWFT != 0) ? FIFO_FWFT : FIFO_STD;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_AF   = CNT_W'(AF_LEVEL);
    localparam logic [CNT_W-1:0] CNT_AE   = CNT_W'(AE_LEVEL);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    if (WIDTH < 1) begin : g_bad_width
        $error("sync_fifo_param: WIDTH must be at least 1");
    end
    if (DEPTH < 2) begin : g_bad_depth
        $error("sync_fifo_param: DEPTH must be at least 2");
    end
    if (AF_LEVEL < 0 || AF_LEVEL > DEPTH) begin : g_bad_af
        $error("sync_fifo_param: AF_LEVEL must lie in 0..DEPTH");
    end
    if (AE_LEVEL < 0 || AE_LEVEL > DEPTH) begin : g_bad_ae
        $error("sync_fifo_param: AE_LEVEL must lie in 0..DEPTH");
    end

    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic [WIDTH-1:0] r_dout;
    logic             r_dout_valid;
    logic             r_overflow;
    logic             r_underflow;

    logic             w_full;
    logic             w_empty;
    logic             w_wr_acc;
    logic             w_rd_acc;
    logic [WIDTH-1:0] w_rdata;

    // Acceptance uses only the registered count, so a full FIFO rejects a write even when a read pops.
    assign w_full   = (r_count == CNT_FULL);
    assign w_empty  = (r_count == '0);
    assign w_wr_acc = bus.i_wr && !w_full;
    assign w_rd_acc = bus.i_rd && !w_empty;

    fifo_sdp_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_ram (
        .i_clk   (i_clk),
        .i_we    (w_wr_acc && !i_rst && !bus.i_flush),
        .i_waddr (r_wr_ptr),
        .i_wdata (bus.i_din),
        .i_raddr (r_rd_ptr),
        .o_rdata (w_rdata)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_dout       <= '0;
            r_dout_valid <= 1'b0;
            r_overflow   <= 1'b0;
            r_underflow  <= 1'b0;
        end else if (bus.i_flush) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_dout       <= '0;
            r_dout_valid <= 1'b0;
        end else begin
            if (w_wr_acc) begin
                r_wr_ptr <= PTR_W'(next_ptr(32'(r_wr_ptr), 32'(DEPTH)));
            end
            if (w_rd_acc) begin
                r_rd_ptr <= PTR_W'(next_ptr(32'(r_rd_ptr), 32'(DEPTH)));
                r_dout   <= w_rdata;
            end
            unique case ({w_wr_acc, w_rd_acc})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
            r_dout_valid <= w_rd_acc;
            if (bus.i_wr && !w_wr_acc) begin
                r_overflow <= 1'b1;
            end
            if (bus.i_rd && !w_rd_acc) begin
                r_underflow <= 1'b1;
            end
        end
    end

    // Fall-through mode presents the head word straight from storage; STD uses the read register.
    if (MODE == FIFO_FWFT) begin : g_fwft
        assign bus.o_dout       = w_empty ? '0 : w_rdata;
        assign bus.o_dout_valid = !w_empty;
    end else begin : g_std
        assign bus.o_dout       = r_dout;
        assign bus.o_dout_valid = r_dout_valid;
    end

    assign bus.o_full         = w_full;
    assign bus.o_empty        = w_empty;
    assign bus.o_almost_full  = (r_count >= CNT_AF);
    assign bus.o_almost_empty = (r_count <= CNT_AE);
    assign bus.o_count        = r_count;
    assign bus.o_overflow     = r_overflow;
    assign bus.o_underflow    = r_underflow;
endmodule
